cheatengine_gen: RTL and testbench
==================================

# cheatengine_gen

Parametrised, pipelined cheat-code engine that sits between a CPU or ROM read path and its data bus. It patches read data whose address matches loaded codes, with configurable bus width and table depth. Over the 16-bit generation it adds an XOR method, one-shot codes, a sequenced table-clear command, a registered read handshake and a hit counter.

## Interface
- ADDR_WIDTH, 20: byte-address width of `addr_in`, at most 32.
- DATA_WIDTH, 16: read bus width; one of 8, 16 or 32.
- MAX_CODES, 32: code table depth, at least 2.
- Derived: LANES = DATA_WIDTH/8; IW = $clog2(MAX_CODES+1).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high. Clears the table and all state. Use it for ROM/code reload, not warm reset.
- enable  in  1  when 0, every read passes through unmodified.
- code  in  129  code word:
  - [128] load strobe, toggled by the loader.
  - [127:96] flags.
  - [95:64] address.
  - [63:32] compare value.
  - [31:0] replace value. Multi-byte fields are pre-ordered by the loader.
- rd_valid  in  1  qualifies `addr_in`/`data_in` this cycle.
- addr_in  in  ADDR_WIDTH  byte address of the read.
- data_in  in  DATA_WIDTH  raw read data.
- data_out  out  DATA_WIDTH  patched data, registered.
- out_valid  out  1  `data_out` valid, exactly 1 cycle after `rd_valid`.
- available  out  1  code_count != 0.
- full  out  1  code_count == MAX_CODES.
- busy  out  1  clear sequence in progress.
- code_count  out  IW  number of stored codes.
- hit_count  out  16  saturating count of output reads where at least one byte was patched.

## Operation
Flag fields in `code`:
- [96] compare enable.
- [102:100] width in bytes: 1, 2 or 4.
- [105:104] method: 0 replace, 1 OR, 2 AND, 3 XOR.
- [106] one-shot.
- [111] clear command.

Window and lanes:
- A code covers a 32-bit window `addr[ADDR_WIDTH-1:2]`.
- Legal (addr[1:0], width) pairs:
  - byte: any offset.
  - half: offset 0 or 2.
  - word: offset 0 only; compare is forced off.
- Any other pair is stored with byte mask 0. It consumes a slot and has no effect.
- The value, compare value and compare mask are shifted into the byte lanes selected by addr[1:0].

Loader FSM, states IDLE and CLEAR:
- A rising edge of code[128] is detected against a registered copy of that bit.
- IDLE, edge with [111]=1 → CLEAR. Index walks 0..MAX_CODES-1 at one entry per cycle, zeroing each entry's mask and active bit. On the final entry, code_count ← 0 and the FSM returns to IDLE. Total MAX_CODES cycles.
- IDLE, edge with [111]=0 and not full → store the entry at index code_count, set active=1, code_count+1.
- Edge while full → ignored.
- Edge while busy → ignored.
- busy=1 exactly while in CLEAR.

Read pipeline:
- Stage 0 combinational:
  - Place `data_in` in the 32-bit window at lane offset addr_in[1:$clog2(LANES)], or offset 0 when DATA_WIDTH=32.
  - Evaluate every active entry whose window matches.
  - An entry applies when (compare XOR window) AND compare_mask == 0.
  - Entries are applied in index order, each to the bytes in its own mask, so the higher index wins on overlapping bytes.
  - Method operates per byte on the original input byte, not on the output of an earlier entry.
- Stage 1 register, on rd_valid:
  - data_out ← the extracted lane.
  - out_valid ← 1.
  - If any byte within the read's lanes changed source, hit_count+1, saturating at 0xFFFF.
- Without rd_valid: out_valid ← 0 and data_out holds.
- `enable`=0 or busy=1 → pass-through, and no one-shot consumption.
- One-shot entry: when it applies to bytes inside the read's lanes on a rd_valid cycle, its active bit clears at that clock edge. The same read is still patched.

## Timing
- Reset values: data_out=0, out_valid=0, code_count=0, available=0, full=0, busy=0, hit_count=0, every entry inactive with mask 0. The code[128] edge register resets to 0.
- Read latency is 1 cycle.
- Back-to-back rd_valid is supported every cycle, with no backpressure.
- A code stored at edge N affects reads with rd_valid in cycle N+1 onward. A read in the same cycle as the store uses the old table.
- One-shot cleared at edge N: a read in cycle N+1 is unpatched by that entry.
- Reset asserted mid-CLEAR or mid-read aborts the operation. The next cycle shows reset values.
- Clear issued at edge N: busy is high in cycles N+1..N+MAX_CODES. code_count reads 0 from cycle N+MAX_CODES+1.
- Holding code[128] high is not a new edge. Only 0→1 transitions count.

## Test plan
- DATA_WIDTH=16: load replace byte, addr 0x1003, data 0xAB, no compare. Read addr 0x1002, data_in 0x1234 → data_out 0xAB34 one cycle later, hit_count=1. Read addr 0x1000 → 0x1234 unchanged.
- Compare half at addr 0x2000, compare 0x5555, value 0x0F0F, method XOR. data_in 0x5555 → 0x5A5A. data_in 0x5556 → 0x5556, hit_count unchanged.
- One-shot OR byte at 0x30, value 0x80. Two consecutive reads of 0x30 with data_in 0x01 → first 0x81, second 0x01. The code stays counted: code_count=1.
- Load MAX_CODES codes → full=1. Load one more → ignored, code_count=MAX_CODES. Issue clear → busy high for MAX_CODES cycles, reads during busy pass through, then code_count=0, available=0.
- Two codes on the same byte, index 0 replace 0x11 and index 1 replace 0x22 → data_out byte 0x22. Word code at misaligned addr 0x41 → stored, no effect.
- DATA_WIDTH=8 and 32 builds: a word replace of 0xDEADBEEF at 0x100.
  - 8-bit: reads of 0x100..0x103 give 0xEF, 0xBE, 0xAD, 0xDE.
  - 32-bit: one read gives 0xDEADBEEF.
  - Asserting reset mid-stream zeroes all outputs the next cycle.

Source files
------------

// File: rtl/cheatengine_gen.sv
// Cheat-code engine: patches registered read data for addresses matching loaded codes.
// Loader accepts codes on rising edges of code[128]; a clear command walks the table.
module cheatengine_gen #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_CODES  = 32,
    localparam int unsigned LANES     = DATA_WIDTH / 8,
    localparam int unsigned IW        = $clog2(MAX_CODES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [128:0]          code,
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  available,
    output logic                  full,
    output logic                  busy,
    output logic [IW-1:0]         code_count,
    output logic [15:0]           hit_count
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [3:0] LANE_BASE = 4'((1 << LANES) - 1);
    localparam logic [1:0] OFF_MASK  = 2'(~(LANES - 1));

    logic [0:0]            r_state;
    logic                  r_strobe;
    logic [IW-1:0]         r_count;
    logic [IW-1:0]         r_clr_idx;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_out_valid;
    logic [15:0]           r_hit;

    logic                  r_active  [MAX_CODES];
    logic                  r_oneshot [MAX_CODES];
    logic [1:0]            r_method  [MAX_CODES];
    logic [3:0]            r_mask    [MAX_CODES];
    logic [ADDR_WIDTH-3:0] r_win     [MAX_CODES];
    logic [31:0]           r_val     [MAX_CODES];
    logic [31:0]           r_cmp     [MAX_CODES];
    logic [31:0]           r_cm      [MAX_CODES];

    logic                  w_edge, w_full, w_store, w_hit;
    logic [1:0]            w_ld_off;
    logic [2:0]            w_ld_width;
    logic [3:0]            w_ld_mask, w_ld_cm;
    logic [31:0]           w_ld_cm32, w_ld_val, w_ld_cmp;
    logic [1:0]            w_byte_off;
    logic [3:0]            w_rd_lanes, w_patched;
    logic [31:0]           w_win, w_out, w_shift;
    logic [MAX_CODES-1:0]  w_consume;

    function automatic logic [7:0] f_apply(input logic [1:0] m, input logic [7:0] a,
                                           input logic [7:0] v);
        case (m)
            2'd0:    f_apply = v;
            2'd1:    f_apply = a | v;
            2'd2:    f_apply = a & v;
            default: f_apply = a ^ v;
        endcase
    endfunction

    assign w_edge  = code[128] & ~r_strobe;
    assign w_full  = (r_count == IW'(MAX_CODES));
    assign w_store = (r_state == ST_IDLE) && w_edge && !code[111] && !w_full;

    assign w_ld_off   = code[65:64];
    assign w_ld_width = code[102:100];

    // Illegal offset/width pairs leave the mask at zero so the slot is inert.
    always_comb begin
        w_ld_mask = 4'b0000;
        case (w_ld_width)
            3'd1:    w_ld_mask = 4'b0001 << w_ld_off;
            3'd2:    w_ld_mask = (w_ld_off == 2'd0) ? 4'b0011 :
                                 (w_ld_off == 2'd2) ? 4'b1100 : 4'b0000;
            3'd4:    w_ld_mask = (w_ld_off == 2'd0) ? 4'b1111 : 4'b0000;
            default: w_ld_mask = 4'b0000;
        endcase
        w_ld_cm = (code[96] && w_ld_width != 3'd4) ? w_ld_mask : 4'b0000;
        for (int b = 0; b < 4; b++) begin
            w_ld_cm32[b*8 +: 8] = {8{w_ld_cm[b]}};
        end
        w_ld_val = code[31:0] << {w_ld_off, 3'b000};
        w_ld_cmp = (code[63:32] << {w_ld_off, 3'b000}) & w_ld_cm32;
    end

    assign w_byte_off = addr_in[1:0] & OFF_MASK;
    assign w_rd_lanes = LANE_BASE << w_byte_off;
    assign w_win      = 32'(data_in) << {w_byte_off, 3'b000};

    // Each entry works on the original window bytes; later indices overwrite earlier ones.
    always_comb begin
        w_out     = w_win;
        w_patched = 4'b0000;
        w_consume = '0;
        if (enable && r_state == ST_IDLE) begin
            for (int i = 0; i < int'(MAX_CODES); i++) begin
                if (r_active[i] && r_win[i] == addr_in[ADDR_WIDTH-1:2] &&
                    (w_win & r_cm[i]) == r_cmp[i]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_mask[i][b]) begin
                            w_out[b*8 +: 8] = f_apply(r_method[i], w_win[b*8 +: 8],
                                                      r_val[i][b*8 +: 8]);
                            w_patched[b]    = 1'b1;
                        end
                    end
                    w_consume[i] = r_oneshot[i] && |(r_mask[i] & w_rd_lanes);
                end
            end
        end
    end

    assign w_shift = w_out >> {w_byte_off, 3'b000};
    assign w_hit   = |(w_patched & w_rd_lanes);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_strobe    <= 1'b0;
            r_count     <= '0;
            r_clr_idx   <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_hit       <= '0;
            for (int i = 0; i < int'(MAX_CODES); i++) begin
                r_active[i]  <= 1'b0;
                r_oneshot[i] <= 1'b0;
                r_method[i]  <= '0;
                r_mask[i]    <= '0;
                r_win[i]     <= '0;
                r_val[i]     <= '0;
                r_cmp[i]     <= '0;
                r_cm[i]      <= '0;
            end
        end else begin
            r_strobe <= code[128];
            if (rd_valid) begin
                r_data_out  <= w_shift[DATA_WIDTH-1:0];
                r_out_valid <= 1'b1;
                if (w_hit && r_hit != 16'hFFFF) r_hit <= r_hit + 16'd1;
            end else begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_edge && code[111]) begin
                        r_state   <= ST_CLEAR;
                        r_clr_idx <= '0;
                    end else if (w_store) begin
                        r_count <= r_count + IW'(1);
                    end
                end
                default: begin
                    if (r_clr_idx == IW'(MAX_CODES - 1)) begin
                        r_state <= ST_IDLE;
                        r_count <= '0;
                    end else begin
                        r_clr_idx <= r_clr_idx + IW'(1);
                    end
                end
            endcase
            for (int i = 0; i < int'(MAX_CODES); i++) begin
                if (rd_valid && w_consume[i]) r_active[i] <= 1'b0;
                if (w_store && r_count == IW'(i)) begin
                    r_active[i]  <= 1'b1;
                    r_oneshot[i] <= code[106];
                    r_method[i]  <= code[105:104];
                    r_mask[i]    <= w_ld_mask;
                    r_win[i]     <= code[ADDR_WIDTH+63:66];
                    r_val[i]     <= w_ld_val;
                    r_cmp[i]     <= w_ld_cmp;
                    r_cm[i]      <= w_ld_cm32;
                end
                if (r_state == ST_CLEAR && r_clr_idx == IW'(i)) begin
                    r_active[i] <= 1'b0;
                    r_mask[i]   <= '0;
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign out_valid  = r_out_valid;
    assign available  = (r_count != '0);
    assign full       = w_full;
    assign busy       = (r_state == ST_CLEAR);
    assign code_count = r_count;
    assign hit_count  = r_hit;
endmodule

// File: tb/tb_cheatengine_gen.sv
// Directed bench for cheatengine_gen: 16-bit/32-entry main instance plus 8- and 32-bit
// two-entry instances sharing an auxiliary loader bus.
module tb_cheatengine_gen;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, rd_valid;
    logic [128:0] code;
    logic [19:0] addr_in;
    logic [15:0] data_in, data_out;
    logic        out_valid, available, full, busy;
    logic [5:0]  code_count;
    logic [15:0] hit_count;

    logic        a_reset, a_enable, a_rd_valid;
    logic [128:0] a_code;
    logic [19:0] a_addr;
    logic [7:0]  d8_in, d8_out;
    logic [31:0] d32_in, d32_out;
    logic        v8, v32, av8, av32, f8, f32, b8, b32;
    logic [1:0]  cc8, cc32;
    logic [15:0] h8, h32;

    int n_checks = 0;
    int n_errors = 0;
    int nb, guard;

    cheatengine_gen #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .MAX_CODES(32)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .code(code), .rd_valid(rd_valid),
        .addr_in(addr_in), .data_in(data_in), .data_out(data_out), .out_valid(out_valid),
        .available(available), .full(full), .busy(busy), .code_count(code_count),
        .hit_count(hit_count)
    );

    cheatengine_gen #(.ADDR_WIDTH(20), .DATA_WIDTH(8), .MAX_CODES(2)) u_dut8 (
        .clk(clk), .reset(a_reset), .enable(a_enable), .code(a_code), .rd_valid(a_rd_valid),
        .addr_in(a_addr), .data_in(d8_in), .data_out(d8_out), .out_valid(v8),
        .available(av8), .full(f8), .busy(b8), .code_count(cc8), .hit_count(h8)
    );

    cheatengine_gen #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .MAX_CODES(2)) u_dut32 (
        .clk(clk), .reset(a_reset), .enable(a_enable), .code(a_code), .rd_valid(a_rd_valid),
        .addr_in(a_addr), .data_in(d32_in), .data_out(d32_out), .out_valid(v32),
        .available(av32), .full(f32), .busy(b32), .code_count(cc32), .hit_count(h32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // flags: [0] compare, [6:4] width, [9:8] method, [10] one-shot, [15] clear
    task automatic load(input logic [31:0] flags, input logic [31:0] addr,
                        input logic [31:0] cmp, input logic [31:0] val);
        code = {1'b1, flags, addr, cmp, val};
        step;
        code[128] = 1'b0;
        step;
    endtask

    task automatic load_a(input logic [31:0] flags, input logic [31:0] addr,
                          input logic [31:0] val);
        a_code = {1'b1, flags, addr, 32'h0, val};
        step;
        a_code[128] = 1'b0;
        step;
    endtask

    task automatic rd(input logic [19:0] addr, input logic [15:0] data);
        rd_valid = 1'b1;
        addr_in  = addr;
        data_in  = data;
        step;
        rd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rd_valid = 1'b0; code = '0; addr_in = '0; data_in = '0;
        a_reset = 1'b1; a_enable = 1'b1; a_rd_valid = 1'b0; a_code = '0; a_addr = '0;
        d8_in = '0; d32_in = '0;
        step; step;
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_count", 32'(code_count), 32'h0);
        chk("rst_available", 32'(available), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hit", 32'(hit_count), 32'h0);
        reset = 1'b0; a_reset = 1'b0; enable = 1'b1;

        // Byte replace at 0x1003
        load(32'h0010, 32'h1003, 32'h0, 32'hAB);
        chk("byte_count", 32'(code_count), 32'd1);
        chk("byte_available", 32'(available), 32'd1);
        rd(20'h1002, 16'h1234);
        chk("byte_patch", 32'(data_out), 32'hAB34);
        chk("byte_valid", 32'(out_valid), 32'd1);
        chk("byte_hit", 32'(hit_count), 32'd1);
        rd(20'h1000, 16'h1234);
        chk("byte_other_lane", 32'(data_out), 32'h1234);
        chk("byte_other_hit", 32'(hit_count), 32'd1);
        step;
        chk("idle_valid_low", 32'(out_valid), 32'd0);
        chk("idle_data_hold", 32'(data_out), 32'h1234);

        // Compare half, XOR
        load(32'h0321, 32'h2000, 32'h5555, 32'h0F0F);
        rd(20'h2000, 16'h5555);
        chk("xor_match", 32'(data_out), 32'h5A5A);
        chk("xor_match_hit", 32'(hit_count), 32'd2);
        rd(20'h2000, 16'h5556);
        chk("xor_nomatch", 32'(data_out), 32'h5556);
        chk("xor_nomatch_hit", 32'(hit_count), 32'd2);

        // One-shot OR byte, back-to-back reads
        load(32'h0510, 32'h0030, 32'h0, 32'h80);
        rd(20'h0030, 16'h0001);
        chk("oneshot_first", 32'(data_out), 32'h0081);
        rd(20'h0030, 16'h0001);
        chk("oneshot_second", 32'(data_out), 32'h0001);
        chk("oneshot_count", 32'(code_count), 32'd3);
        chk("oneshot_hit", 32'(hit_count), 32'd3);

        enable = 1'b0;
        rd(20'h1002, 16'h1234);
        chk("disable_pass", 32'(data_out), 32'h1234);
        chk("disable_hit", 32'(hit_count), 32'd3);
        enable = 1'b1;

        // Overlap: higher index wins; misaligned word is inert
        load(32'h0010, 32'h0050, 32'h0, 32'h11);
        load(32'h0010, 32'h0050, 32'h0, 32'h22);
        rd(20'h0050, 16'hFFFF);
        chk("overlap", 32'(data_out), 32'hFF22);
        chk("overlap_hit", 32'(hit_count), 32'd4);
        load(32'h0040, 32'h0041, 32'h0, 32'hDEADBEEF);
        chk("misalign_count", 32'(code_count), 32'd6);
        rd(20'h0040, 16'h0000);
        chk("misalign_lo", 32'(data_out), 32'h0000);
        rd(20'h0042, 16'h0000);
        chk("misalign_hi", 32'(data_out), 32'h0000);
        chk("misalign_hit", 32'(hit_count), 32'd4);

        // Read in the store cycle sees the old table; held strobe is not a new edge
        code = {1'b1, 32'h0010, 32'h0060, 32'h0, 32'h77};
        rd(20'h0060, 16'h0000);
        chk("same_cycle_old", 32'(data_out), 32'h0000);
        chk("same_cycle_count", 32'(code_count), 32'd7);
        rd(20'h0060, 16'h0000);
        chk("next_cycle_new", 32'(data_out), 32'h0077);
        chk("held_strobe_count", 32'(code_count), 32'd7);
        code[128] = 1'b0;
        step;

        // Fill to MAX_CODES, then one ignored load
        for (int i = 0; i < 25; i++) begin
            load(32'h0010, 32'h0700 + 32'(i) * 4, 32'h0, 32'h5A);
        end
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(code_count), 32'd32);
        load(32'h0010, 32'h0090, 32'h0, 32'h99);
        chk("full_ignored_count", 32'(code_count), 32'd32);
        rd(20'h0090, 16'h0000);
        chk("full_ignored_read", 32'(data_out), 32'h0000);
        chk("pre_clear_hit", 32'(hit_count), 32'd5);

        // Clear: busy for exactly MAX_CODES sampled cycles, reads pass through
        nb = 0;
        code = {1'b1, 32'h8000, 96'h0};
        step;
        chk("clear_busy_start", 32'(busy), 32'd1);
        if (busy) nb++;
        code[128] = 1'b0;
        rd(20'h1002, 16'h1234);
        if (busy) nb++;
        chk("clear_passthru", 32'(data_out), 32'h1234);
        chk("clear_passthru_hit", 32'(hit_count), 32'd5);
        guard = 0;
        while (busy && guard < 100) begin
            step;
            if (busy) nb++;
            guard++;
        end
        chk("clear_busy_cycles", 32'(nb), 32'd32);
        chk("clear_busy_end", 32'(busy), 32'd0);
        chk("clear_count", 32'(code_count), 32'd0);
        chk("clear_available", 32'(available), 32'd0);
        chk("clear_full", 32'(full), 32'd0);
        rd(20'h1002, 16'h1234);
        chk("clear_table_empty", 32'(data_out), 32'h1234);

        // Reset mid-read
        load(32'h0010, 32'h1003, 32'h0, 32'hAB);
        rd(20'h1002, 16'h1234);
        chk("reload_patch", 32'(data_out), 32'hAB34);
        reset = 1'b1; rd_valid = 1'b1; addr_in = 20'h1002; data_in = 16'h1234;
        step;
        rd_valid = 1'b0; reset = 1'b0;
        chk("midrst_data", 32'(data_out), 32'h0);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_count", 32'(code_count), 32'h0);
        chk("midrst_hit", 32'(hit_count), 32'h0);

        // 8- and 32-bit builds: word replace at 0x100
        load_a(32'h0040, 32'h0100, 32'hDEADBEEF);
        chk("w32_count", 32'(cc32), 32'd1);
        a_rd_valid = 1'b1; a_addr = 20'h100; d8_in = 8'h00; d32_in = 32'h0;
        step;
        chk("w32_read", d32_out, 32'hDEADBEEF);
        chk("w8_b0", 32'(d8_out), 32'hEF);
        a_addr = 20'h101; step;
        chk("w8_b1", 32'(d8_out), 32'hBE);
        a_addr = 20'h102; step;
        chk("w8_b2", 32'(d8_out), 32'hAD);
        a_addr = 20'h103; step;
        chk("w8_b3", 32'(d8_out), 32'hDE);
        chk("w8_hit", 32'(h8), 32'd4);
        a_rd_valid = 1'b0;
        load_a(32'h0010, 32'h0200, 32'h11);
        chk("a8_full", 32'(f8), 32'd1);
        chk("a32_full", 32'(f32), 32'd1);
        a_rd_valid = 1'b1; a_addr = 20'h100; a_reset = 1'b1;
        step;
        a_rd_valid = 1'b0; a_reset = 1'b0;
        chk("a8_rst_data", 32'(d8_out), 32'h0);
        chk("a32_rst_data", d32_out, 32'h0);
        chk("a32_rst_valid", 32'(v32), 32'h0);
        chk("a8_rst_valid", 32'(v8), 32'h0);
        chk("a32_rst_hit", 32'(h32), 32'h0);
        chk("a8_rst_count", 32'(cc8), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
